// File: rtl/sbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sbuf_pkg
// Description : Shared types and constants for the sbuf run sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sbuf_pkg;

    localparam int LEN_W   = 8;
    localparam int LAT_W   = 5;
    localparam int ADR_W   = 9;
    localparam int SAT_SEL = 8;    // read address bit selecting the saturation buffer

    localparam logic RQ_CPU = 1'b0;
    localparam logic RQ_DMA = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_FILL     = 3'd2,
        ST_STREAM   = 3'd3,
        ST_ABORT    = 3'd4,
        ST_WAIT_FIN = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

endpackage : sbuf_pkg
`default_nettype wire

// File: rtl/sbuf_if.sv
`default_nettype none
// ============================================================================
// Module      : sbuf_if
// Description : Control and read-address bundle between sequencer and sbuf.
// Revision    : 1.0 - initial release
// ============================================================================
interface sbuf_if #(
    parameter int LEN_W = 8,
    parameter int ADR_W = 9
) ();
    logic             sb_start;
    logic [LEN_W-1:0] sb_run_cntr;
    logic             sb_sw;
    logic             sb_running;
    logic             sb_finish;
    logic [ADR_W-1:0] sb_radr;

    modport master (
        output sb_start, sb_run_cntr, sb_sw, sb_radr,
        input  sb_running, sb_finish
    );

    modport slave (
        input  sb_start, sb_run_cntr, sb_sw, sb_radr,
        output sb_running, sb_finish
    );
endinterface : sbuf_if
`default_nettype wire

// File: rtl/sbuf_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : sbuf_rd_arb
// Description : 2-way round-robin arbiter for the sbuf read port, with
//               address mux and 1-cycle read-valid pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module sbuf_rd_arb
    import sbuf_pkg::*;
#(
    parameter int ADR_W = 9
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    input  wire logic             i_cpu_rreq,
    input  wire logic [ADR_W-1:0] i_cpu_radr,
    input  wire logic             i_dma_rreq,
    input  wire logic [ADR_W-1:0] i_dma_radr,
    output logic                  o_cpu_gnt,
    output logic                  o_dma_gnt,
    output logic      [ADR_W-1:0] o_radr,
    output logic                  o_rd_vld_cpu,
    output logic                  o_rd_vld_dma
);

    logic r_ptr;
    logic r_vld_cpu;
    logic r_vld_dma;
    logic w_cpu_gnt;
    logic w_dma_gnt;

    // r_ptr names the requester that wins a tie
    assign w_cpu_gnt = i_en & i_cpu_rreq & (~i_dma_rreq | (r_ptr == RQ_CPU));
    assign w_dma_gnt = i_en & i_dma_rreq & (~i_cpu_rreq | (r_ptr == RQ_DMA));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= RQ_CPU;
            r_vld_cpu <= 1'b0;
            r_vld_dma <= 1'b0;
        end else begin
            if (w_cpu_gnt) begin
                r_ptr <= RQ_DMA;
            end else if (w_dma_gnt) begin
                r_ptr <= RQ_CPU;
            end
            r_vld_cpu <= w_cpu_gnt;
            r_vld_dma <= w_dma_gnt;
        end
    end

    always_comb begin
        o_radr = '0;
        if (w_cpu_gnt) begin
            o_radr = i_cpu_radr;
        end else if (w_dma_gnt) begin
            o_radr = i_dma_radr;
        end
    end

    assign o_cpu_gnt    = w_cpu_gnt;
    assign o_dma_gnt    = w_dma_gnt;
    assign o_rd_vld_cpu = r_vld_cpu;
    assign o_rd_vld_dma = r_vld_dma;

endmodule : sbuf_rd_arb
`default_nettype wire

// File: rtl/sbuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sbuf_ctrl
// Description : Sequences one systolic-array result run into the output
//               buffer and arbitrates the buffer read port between readers.
// Revision    : 1.0 - initial release
// ============================================================================
module sbuf_ctrl
    import sbuf_pkg::*;
#(
    parameter int LEN_W = sbuf_pkg::LEN_W,
    parameter int LAT_W = sbuf_pkg::LAT_W,
    parameter int TMO   = 1023,
    parameter int ADR_W = sbuf_pkg::ADR_W
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             cpu_start,
    input  wire logic             cpu_abort,
    input  wire logic [LEN_W-1:0] cpu_len,
    input  wire logic [LAT_W-1:0] cpu_lat,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  irq,
    input  wire logic             irq_clr,
    input  wire logic             arr_ovalid,
    input  wire logic             cpu_rreq,
    input  wire logic [ADR_W-1:0] cpu_radr,
    input  wire logic             dma_rreq,
    input  wire logic [ADR_W-1:0] dma_radr,
    output logic                  cpu_gnt,
    output logic                  dma_gnt,
    output logic                  rd_vld_cpu,
    output logic                  rd_vld_dma,
    sbuf_if.master                sb
);

    localparam int STL_W = $clog2(TMO + 1);

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_len;
    logic [LAT_W-1:0] r_lat;
    logic [LAT_W-1:0] r_fill_cnt;
    logic [LEN_W-1:0] r_wcnt;
    logic [STL_W-1:0] r_stall;
    logic             r_err;
    logic             r_irq;

    logic             w_busy;
    logic             w_done;
    logic             w_sb_start;
    logic [LEN_W-1:0] w_run_cntr;
    logic             w_sw;
    logic             w_last_sw;
    logic             w_stall_to;
    logic             w_rd_en;
    logic [ADR_W-1:0] w_radr;

    assign w_last_sw  = w_sw && (r_wcnt == (r_len - LEN_W'(1)));
    assign w_stall_to = !arr_ovalid && (r_stall == STL_W'(TMO - 1));

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cpu_start) begin
                    w_next = (cpu_len == '0) ? ST_DONE : ST_START;
                end
            end
            ST_START: begin
                if (cpu_abort)          w_next = ST_ABORT;
                else if (r_lat == '0)   w_next = ST_STREAM;
                else                    w_next = ST_FILL;
            end
            ST_FILL: begin
                if (cpu_abort)                    w_next = ST_ABORT;
                else if (r_fill_cnt == LAT_W'(1)) w_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (cpu_abort)       w_next = ST_ABORT;
                else if (w_last_sw)  w_next = sb.sb_finish ? ST_DONE : ST_WAIT_FIN;
                else if (w_stall_to) w_next = ST_ABORT;
            end
            ST_ABORT:    w_next = ST_WAIT_FIN;
            ST_WAIT_FIN: begin
                if (sb.sb_finish) w_next = ST_DONE;
            end
            ST_DONE:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_busy     = (r_state != ST_IDLE);
        w_done     = 1'b0;
        w_sb_start = 1'b0;
        w_run_cntr = '0;
        w_sw       = 1'b0;
        case (r_state)
            ST_START: begin
                w_sb_start = 1'b1;
                w_run_cntr = r_len;
            end
            // Zero count makes the buffer flush its partial word and finish
            ST_ABORT: begin
                w_sb_start = 1'b1;
                w_run_cntr = '0;
            end
            ST_STREAM: w_sw = arr_ovalid && (r_wcnt != r_len);
            ST_DONE:   w_done = 1'b1;
            default:   ;
        endcase
    end

    // ------------------------------------------------- counters and status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len      <= '0;
            r_lat      <= '0;
            r_fill_cnt <= '0;
            r_wcnt     <= '0;
            r_stall    <= '0;
            r_err      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && cpu_start) begin
                r_len <= cpu_len;
                r_lat <= cpu_lat;
            end

            if (r_state == ST_START) begin
                r_fill_cnt <= r_lat;
            end else if (r_state == ST_FILL) begin
                r_fill_cnt <= r_fill_cnt - LAT_W'(1);
            end

            if (r_state == ST_START) begin
                r_wcnt <= '0;
            end else if (w_sw) begin
                r_wcnt <= r_wcnt + LEN_W'(1);
            end

            if (r_state != ST_STREAM || arr_ovalid) begin
                r_stall <= '0;
            end else begin
                r_stall <= r_stall + STL_W'(1);
            end

            // A new set in the same cycle as irq_clr wins
            if (r_state == ST_ABORT || (cpu_start && w_busy)) begin
                r_err <= 1'b1;
            end else if (irq_clr) begin
                r_err <= 1'b0;
            end

            if (r_state == ST_DONE) begin
                r_irq <= 1'b1;
            end else if (irq_clr) begin
                r_irq <= 1'b0;
            end
        end
    end

    // Reads only while idle and not about to leave idle
    assign w_rd_en = (r_state == ST_IDLE) && !cpu_start;

    sbuf_rd_arb #(
        .ADR_W (ADR_W)
    ) u_rd_arb (
        .clk          (clk),
        .rst          (rst),
        .i_en         (w_rd_en),
        .i_cpu_rreq   (cpu_rreq),
        .i_cpu_radr   (cpu_radr),
        .i_dma_rreq   (dma_rreq),
        .i_dma_radr   (dma_radr),
        .o_cpu_gnt    (cpu_gnt),
        .o_dma_gnt    (dma_gnt),
        .o_radr       (w_radr),
        .o_rd_vld_cpu (rd_vld_cpu),
        .o_rd_vld_dma (rd_vld_dma)
    );

    assign busy           = w_busy;
    assign done           = w_done;
    assign err            = r_err;
    assign irq            = r_irq;
    assign sb.sb_start    = w_sb_start;
    assign sb.sb_run_cntr = w_run_cntr;
    assign sb.sb_sw       = w_sw;
    assign sb.sb_radr     = w_radr;

endmodule : sbuf_ctrl
`default_nettype wire

// File: tb/tb_sbuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sbuf_ctrl
// Description : Directed self-checking bench for sbuf_ctrl (TMO reduced to 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sbuf_ctrl;

    localparam int LEN_W = 8;
    localparam int LAT_W = 5;
    localparam int ADR_W = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             cpu_start, cpu_abort, irq_clr, arr_ovalid;
    logic [LEN_W-1:0] cpu_len;
    logic [LAT_W-1:0] cpu_lat;
    logic             busy, done, err, irq;
    logic             cpu_rreq, dma_rreq;
    logic [ADR_W-1:0] cpu_radr, dma_radr;
    logic             cpu_gnt, dma_gnt, rd_vld_cpu, rd_vld_dma;

    int n_vec = 0;
    int n_err = 0;

    // Observation results
    int o_sw, o_st, o_first_sw, o_first_st, o_cntr;

    sbuf_if #(.LEN_W(LEN_W), .ADR_W(ADR_W)) sb ();

    sbuf_ctrl #(
        .LEN_W (LEN_W),
        .LAT_W (LAT_W),
        .TMO   (8),
        .ADR_W (ADR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_start  (cpu_start),
        .cpu_abort  (cpu_abort),
        .cpu_len    (cpu_len),
        .cpu_lat    (cpu_lat),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .irq        (irq),
        .irq_clr    (irq_clr),
        .arr_ovalid (arr_ovalid),
        .cpu_rreq   (cpu_rreq),
        .cpu_radr   (cpu_radr),
        .dma_rreq   (dma_rreq),
        .dma_radr   (dma_radr),
        .cpu_gnt    (cpu_gnt),
        .dma_gnt    (dma_gnt),
        .rd_vld_cpu (rd_vld_cpu),
        .rd_vld_dma (rd_vld_dma),
        .sb         (sb)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sample n cycles starting now, counting start pulses and write strobes
    task automatic observe(input int n);
        o_sw = 0; o_st = 0; o_first_sw = -1; o_first_st = -1; o_cntr = -1;
        for (int i = 0; i < n; i++) begin
            if (sb.sb_sw) begin
                if (o_first_sw < 0) o_first_sw = i;
                o_sw++;
            end
            if (sb.sb_start) begin
                if (o_first_st < 0) begin
                    o_first_st = i;
                    o_cntr     = int'(sb.sb_run_cntr);
                end
                o_st++;
            end
            tick();
        end
    endtask

    task automatic finish_run(input string tag);
        sb.sb_finish = 1'b1;
        tick();
        sb.sb_finish = 1'b0;
        #1;
        chk({tag, "_done"}, done, 1'b1);
        tick();
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic clear_irq;
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] pat;
        logic [8:0] mask;
        int         found;
        logic       any_gnt;

        rst = 1'b1;
        cpu_start = 1'b0; cpu_abort = 1'b0; irq_clr = 1'b0; arr_ovalid = 1'b0;
        cpu_len = '0; cpu_lat = '0;
        cpu_rreq = 1'b0; dma_rreq = 1'b0; cpu_radr = '0; dma_radr = '0;
        sb.sb_finish = 1'b0; sb.sb_running = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_start", sb.sb_start, 1'b0);
        chk("rst_sw", sb.sb_sw, 1'b0);

        // Nominal: len=4 lat=3, valid held high
        cpu_len = 8'd4; cpu_lat = 5'd3; arr_ovalid = 1'b1; cpu_start = 1'b1;
        #1;
        chk("nom_nostart_t0", sb.sb_start, 1'b0);
        tick();
        cpu_start = 1'b0;
        #1;
        observe(10);
        chk("nom_start_cnt", o_st, 1);
        chk("nom_start_idx", o_first_st, 0);
        chk("nom_run_cntr", o_cntr, 4);
        chk("nom_sw_cnt", o_sw, 4);
        chk("nom_first_sw", o_first_sw, 4);
        chk("nom_wait_busy", busy, 1'b1);
        finish_run("nom");
        chk("nom_irq", irq, 1'b1);
        chk("nom_err", err, 1'b0);

        // Zero length: straight to DONE
        cpu_len = 8'd0; cpu_start = 1'b1;
        tick();
        cpu_start = 1'b0;
        #1;
        chk("len0_done", done, 1'b1);
        chk("len0_nostart", sb.sb_start, 1'b0);
        chk("len0_nosw", sb.sb_sw, 1'b0);
        tick();
        chk("len0_done_clr", done, 1'b0);
        chk("len0_idle", busy, 1'b0);

        // Gapped valid: len=5, lat=0
        arr_ovalid = 1'b0; cpu_len = 8'd5; cpu_lat = 5'd0; cpu_start = 1'b1;
        tick();
        cpu_start = 1'b0;
        #1;
        chk("gap_start", sb.sb_start, 1'b1);
        chk("gap_cntr", sb.sb_run_cntr, 8'd5);
        tick();
        pat  = 9'b111011001;
        mask = '0;
        for (int i = 0; i < 9; i++) begin
            arr_ovalid = pat[i];
            #1;
            if (sb.sb_sw) mask[i] = 1'b1;
            tick();
        end
        arr_ovalid = 1'b0;
        chk("gap_sw_mask", mask, 9'b011011001);
        finish_run("gap");

        // Watchdog: valid stuck low in STREAM
        clear_irq();
        cpu_len = 8'd4; cpu_lat = 5'd0; cpu_start = 1'b1;
        tick();
        cpu_start = 1'b0;
        tick();
        found = -1;
        for (int i = 0; i < 20; i++) begin
            if (sb.sb_start) begin
                found = i;
                break;
            end
            tick();
        end
        chk("wdg_abort_cycle", found, 8);
        chk("wdg_cntr0", sb.sb_run_cntr, 8'd0);
        tick();
        chk("wdg_err", err, 1'b1);
        finish_run("wdg");
        chk("wdg_irq", irq, 1'b1);

        // Abort in FILL
        clear_irq();
        chk("clr_err", err, 1'b0);
        chk("clr_irq", irq, 1'b0);
        cpu_len = 8'd4; cpu_lat = 5'd3; cpu_start = 1'b1;
        tick();
        cpu_start = 1'b0;
        tick();
        cpu_abort = 1'b1;
        tick();
        cpu_abort = 1'b0;
        #1;
        chk("abt_start", sb.sb_start, 1'b1);
        chk("abt_cntr0", sb.sb_run_cntr, 8'd0);
        tick();
        chk("abt_err", err, 1'b1);
        finish_run("abt");
        clear_irq();

        // Start while busy in STREAM
        cpu_len = 8'd2; cpu_lat = 5'd0; cpu_start = 1'b1;
        tick();
        cpu_start = 1'b0;
        tick();
        cpu_start = 1'b1;
        tick();
        cpu_start = 1'b0;
        #1;
        chk("sbz_err", err, 1'b1);
        chk("sbz_busy", busy, 1'b1);
        arr_ovalid = 1'b1;
        #1;
        chk("sbz_sw", sb.sb_sw, 1'b1);
        tick(); tick();
        arr_ovalid = 1'b0;
        #1;
        chk("sbz_wait_nosw", sb.sb_sw, 1'b0);
        finish_run("sbz");
        clear_irq();
        chk("sbz_clr_err", err, 1'b0);
        chk("sbz_clr_irq", irq, 1'b0);

        // Read arbitration
        cpu_rreq = 1'b1; dma_rreq = 1'b1; cpu_radr = 9'h123; dma_radr = 9'h045;
        #1;
        chk("arb0_cpu_gnt", cpu_gnt, 1'b1);
        chk("arb0_dma_gnt", dma_gnt, 1'b0);
        chk("arb0_radr", sb.sb_radr, 9'h123);
        tick();
        chk("arb1_vld_cpu", rd_vld_cpu, 1'b1);
        chk("arb1_dma_gnt", dma_gnt, 1'b1);
        chk("arb1_cpu_gnt", cpu_gnt, 1'b0);
        chk("arb1_radr", sb.sb_radr, 9'h045);
        tick();
        chk("arb2_vld_dma", rd_vld_dma, 1'b1);
        chk("arb2_vld_cpu", rd_vld_cpu, 1'b0);
        chk("arb2_cpu_gnt", cpu_gnt, 1'b1);
        tick();
        cpu_len = 8'd1; cpu_lat = 5'd2; arr_ovalid = 1'b1; cpu_start = 1'b1;
        #1;
        chk("arb3_leave_nognt", cpu_gnt | dma_gnt, 1'b0);
        chk("arb3_radr0", sb.sb_radr, 9'h000);
        tick();
        cpu_start = 1'b0;
        any_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            any_gnt = any_gnt | cpu_gnt | dma_gnt;
            tick();
        end
        arr_ovalid = 1'b0;
        chk("arb_busy_nognt", any_gnt, 1'b0);
        sb.sb_finish = 1'b1;
        tick();
        sb.sb_finish = 1'b0;
        #1;
        chk("arb_done_nognt", cpu_gnt | dma_gnt, 1'b0);
        tick();
        chk("arb_resume_dma", dma_gnt, 1'b1);
        chk("arb_resume_cpu", cpu_gnt, 1'b0);
        chk("arb_resume_radr", sb.sb_radr, 9'h045);
        tick();
        chk("arb_resume_vld", rd_vld_dma, 1'b1);
        chk("arb_resume_cpu2", cpu_gnt, 1'b1);
        cpu_rreq = 1'b0; dma_rreq = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sbuf_ctrl
`default_nettype wire
